multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit RISC core.
- Sequences fetch/decode/execute/memory/writeback.
- Drives the select lines of the datapath multiplexers: 1-bit register-destination select (4-bit), 2-bit PC-source select (8-bit, with zero vector) and 1-bit ALU-B select (16-bit).
- Also drives the PC, IR, register-file and memory strobes, and handshakes with a variable-latency memory.

Parameters:
- OPW, 4, opcode width.
- WAIT_MAX, 15, max cycles to wait for mem_ready before fault (1..2^CNTW-1).
- CNTW, 4, wait-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE/HALT and begin execution from PC=0.
- opcode  input  OPW  IR[15:12]; valid from DECODE onward.
- zero  input  1  ALU zero flag, sampled in EXEC.
- mem_ready  input  1  memory completes current read/write this cycle.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load IR.
- pc_write  output  1  load PC.
- pc_sel  output  2  00 PC+1, 01 branch/jump target, 10 zero vector.
- alu_b_sel  output  1  0 register operand, 1 sign-extended immediate.
- rd_sel  output  1  0 IR[11:8] (R-type), 1 IR[7:4] (ADDI/LD).
- reg_write  output  1  register-file write enable.
- halted  output  1  FSM in HALT.
- fault  output  1  sticky memory-timeout flag; cleared by reset or start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; op_q=0; wait_cnt=0; fault=0.
  - All strobes 0; pc_sel=00, alu_b_sel=0, rd_sel=0, halted=0.
- Reset mid-operation aborts immediately; no strobe may glitch high during reset.
- Outputs are combinational from state, op_q and mem_ready. op_q is captured from opcode at the end of DECODE.
- Opcode classes:
  - 0x0-0x7 ALU R-type
  - 0x8 ADDI
  - 0x9 LD
  - 0xA ST
  - 0xB BEQ
  - 0xC JMP
  - 0xD-0xE NOP
  - 0xF HLT
- IDLE: all strobes 0. On start: pc_write=1, pc_sel=10, clear fault -> FETCH.
- FETCH: mem_read=1.
  - If mem_ready: ir_write=1, pc_write=1, pc_sel=00 -> DECODE.
  - Else increment wait_cnt.
- DECODE: one cycle; latch op_q -> EXEC.
- EXEC:
  - ALU: alu_b_sel=0 -> WB.
  - ADDI/LD/ST: alu_b_sel=1. ADDI -> WB; LD/ST -> MEM.
  - BEQ: if zero, pc_write=1, pc_sel=01; -> FETCH.
  - JMP: pc_write=1, pc_sel=01 -> FETCH.
  - NOP: -> FETCH.
  - HLT: -> HALT.
- MEM:
  - LD: mem_read=1; on mem_ready -> WB.
  - ST: mem_write=1; on mem_ready -> FETCH.
  - alu_b_sel held at 1 throughout.
- WB: reg_write=1; rd_sel=1 for ADDI/LD, 0 for ALU -> FETCH.
- HALT: halted=1, strobes 0; start -> same action as from IDLE.
- Wait counter:
  - Clears on every state entry.
  - In FETCH/MEM, if wait_cnt reaches WAIT_MAX with mem_ready still low: set fault, drop request -> HALT.
  - mem_ready in the same cycle as the limit wins (no fault).
- mem_read and mem_write are never both high. Requests stay asserted until mem_ready or timeout.
- Latency with zero-wait memory:
  - ALU/ADDI 4 cycles; LD 5; ST 4; BEQ/JMP/NOP 3; HLT 3 to HALT.
- start is ignored outside IDLE/HALT.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - 0xD-0xE are illegal.
  - EXEC asserts pc_write=1 with pc_sel=10 (vector to 0), pulses output illegal_op for one cycle, then goes to FETCH.
- Undefined:
  - 0xD-0xE execute as NOP.
  - No illegal_op port exists.

Decomposition:
- Shared package multicycle_pkg holds:
  - State enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants.
  - pc_sel encodings (PCSEL_INC, PCSEL_TGT, PCSEL_ZERO).
  - rd_sel and alu_b_sel encodings.
- One natural sub-module: mem_wait_timer (counter, clear-on-entry, timeout compare, parameterised WAIT_MAX/CNTW).

Test Plan:
- Reset mid-MEM of LD (rst_n low while mem_read=1) -> next cycle all strobes 0, state IDLE, fault=0, even with mem_ready high.
- start, then opcode 0x1, mem_ready tied 1 -> IDLE pc_sel=10/pc_write; FETCH ir_write+pc_write pc_sel=00; EXEC alu_b_sel=0; WB reg_write=1 rd_sel=0; exactly 4 cycles per instruction.
- LD (0x9) with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles, alu_b_sel=1; then WB reg_write=1 rd_sel=1; ST (0xA) -> mem_write only, no reg_write.
- BEQ with zero=1 -> pc_write=1 pc_sel=01 in EXEC. BEQ with zero=0 -> no pc_write in EXEC. JMP always pc_sel=01.
- mem_ready never asserted in FETCH, WAIT_MAX=15 -> mem_read drops after 15 waiting cycles, fault=1, halted=1. mem_ready on cycle 15 -> no fault. start clears fault.
- HLT (0xF) -> halted=1, strobes 0, start ignored mid-run. Opcode 0xD -> NOP without macro; with macro pc_sel=10 pc_write=1 and illegal_op pulses once.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_pkg: shared states, opcode classes and datapath select encodings
// for the multi-cycle control FSM of the 16-bit RISC core.
`default_nettype none

package multicycle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_NOP0 = 4'hD;
  localparam logic [3:0] OP_NOP1 = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] PCSEL_INC  = 2'b00;
  localparam logic [1:0] PCSEL_TGT  = 2'b01;
  localparam logic [1:0] PCSEL_ZERO = 2'b10;

  localparam logic RDSEL_RTYPE = 1'b0;
  localparam logic RDSEL_IMM   = 1'b1;
  localparam logic ALUB_REG    = 1'b0;
  localparam logic ALUB_IMM    = 1'b1;

  // Opcodes 0x0-0x7 are all register-register ALU operations.
  function automatic logic is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/handshake bundle between the multi-cycle FSM
// (master) and the datapath plus memory (slave).
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int OPW = 4
) ();

  logic           start;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           pc_write;
  logic [1:0]     pc_sel;
  logic           alu_b_sel;
  logic           rd_sel;
  logic           reg_write;
  logic           halted;
  logic           fault;

  modport master (
    input  start, opcode, zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_sel,
           alu_b_sel, rd_sel, reg_write, halted, fault
  );

  modport slave (
    output start, opcode, zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_sel,
           alu_b_sel, rd_sel, reg_write, halted, fault
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits for ready; flags the
// WAIT_MAX-th consecutive waiting cycle as a timeout. Cleared on state entry.
`default_nettype none

module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int CNTW     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam logic [CNTW-1:0] LIMIT = CNTW'(WAIT_MAX - 1);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = wait_i && (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the 16-bit
// RISC core. MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps 0xD/0xE and adds illegal_op.
`default_nettype none

module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNTW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  output logic              illegal_op,
`endif
  multicycle_ctrl_if.master bus
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           fault_q, fault_d;

  logic       mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_sel;
  logic       alu_b_sel, rd_sel, reg_write;
  logic       timer_wait, timeout;
  logic [3:0] op;

  assign op = 4'(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fault_q <= fault_d;
    end
  end

  assign timer_wait = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ready;

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNTW     (CNTW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .wait_i    (timer_wait),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fault_d   = fault_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PCSEL_INC;
    alu_b_sel = ALUB_REG;
    rd_sel    = RDSEL_RTYPE;
    reg_write = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif

    case (state_q)
      // rst_n qualifies start so pc_write cannot rise while reset is held.
      IDLE, HALT: begin
        if (bus.start && rst_n) begin
          pc_write = 1'b1;
          pc_sel   = PCSEL_ZERO;
          fault_d  = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      DECODE: begin
        op_d    = bus.opcode;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        if (is_alu(op)) begin
          state_d = WB;
        end else begin
          case (op)
            OP_ADDI: begin
              alu_b_sel = ALUB_IMM;
              state_d   = WB;
            end
            OP_LD, OP_ST: begin
              alu_b_sel = ALUB_IMM;
              state_d   = MEM;
            end
            OP_BEQ: begin
              if (bus.zero) begin
                pc_write = 1'b1;
                pc_sel   = PCSEL_TGT;
              end
            end
            OP_JMP: begin
              pc_write = 1'b1;
              pc_sel   = PCSEL_TGT;
            end
            OP_HLT: state_d = HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            OP_NOP0, OP_NOP1: begin
              pc_write   = 1'b1;
              pc_sel     = PCSEL_ZERO;
              illegal_op = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      MEM: begin
        alu_b_sel = ALUB_IMM;
        if (op == OP_LD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = (op == OP_LD) ? WB : FETCH;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      WB: begin
        reg_write = 1'b1;
        rd_sel    = ((op == OP_ADDI) || (op == OP_LD)) ? RDSEL_IMM : RDSEL_RTYPE;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.rd_sel    = rd_sel;
  assign bus.reg_write = reg_write;
  assign bus.halted    = (state_q == HALT);
  assign bus.fault     = fault_q;

endmodule

`default_nettype wire
